imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_if.sv | 22 ++
 rtl/imem_boot_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Stream-in handshake and instruction-memory write bus of the boot loader.
// The loader takes the slave view; the stream source / memory side takes the master view.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a framed little-endian byte stream (length, words, XOR checksum) into
// instruction memory and holds the core in reset until the image verifies.
module imem_boot_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  output logic                core_reset,
  output logic                load_done,
  output logic                load_error
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [7:0]        len_lo_r;
  logic [15:0]       len_full_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  word_cnt_r;
  logic [1:0]        lane_r;
  logic [7:0]        csum_r;
  logic [23:0]       part_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              core_reset_r;
  logic              load_done_r;
  logic              load_error_r;
  logic              ready_s;
  logic              accept_s;
  logic              last_word_s;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] data);
    csum_next = acc ^ data;
  endfunction

  assign ready_s     = (state_r != S_DONE);
  assign accept_s    = bus.in_valid && ready_s;
  assign len_full_s  = {bus.in_data, len_lo_r};
  assign last_word_s = ((word_cnt_r + CNT_W'(1)) == count_r);

  assign bus.in_ready   = ready_s;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;
  assign core_reset     = core_reset_r;
  assign load_done      = load_done_r;
  assign load_error     = load_error_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_LEN_LO;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; only an accepted byte can move the frame forward.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      case (state_r)
        S_LEN_LO: state_nxt_s = S_LEN_HI;
        S_LEN_HI: begin
          if (len_full_s == 16'd0) begin
            state_nxt_s = S_CSUM;
          end else if (len_full_s > 16'(DEPTH)) begin
            state_nxt_s = S_ERR;
          end else begin
            state_nxt_s = S_DATA;
          end
        end
        S_DATA: begin
          if ((lane_r == 2'd3) && last_word_s) begin
            state_nxt_s = S_CSUM;
          end else begin
            state_nxt_s = S_DATA;
          end
        end
        S_CSUM: begin
          if (bus.in_data == csum_r) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_ERR;
          end
        end
        S_DONE:  state_nxt_s = S_DONE;
        S_ERR:   state_nxt_s = S_ERR;
        default: state_nxt_s = S_ERR;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Byte assembly, checksum, write strobe and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo_r     <= 8'd0;
      count_r      <= '0;
      word_cnt_r   <= '0;
      lane_r       <= 2'd0;
      csum_r       <= 8'd0;
      part_r       <= 24'd0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 32'd0;
      core_reset_r <= 1'b1;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
    end else begin
      we_r         <= 1'b0;
      core_reset_r <= (state_nxt_s != S_DONE);
      load_done_r  <= (state_nxt_s == S_DONE);
      load_error_r <= (state_nxt_s == S_ERR);
      if (accept_s) begin
        case (state_r)
          S_LEN_LO: begin
            len_lo_r <= bus.in_data;
            csum_r   <= csum_next(csum_r, bus.in_data);
          end
          S_LEN_HI: begin
            count_r <= len_full_s[CNT_W-1:0];
            csum_r  <= csum_next(csum_r, bus.in_data);
          end
          S_DATA: begin
            csum_r <= csum_next(csum_r, bus.in_data);
            lane_r <= lane_r + 2'd1;
            case (lane_r)
              2'd0: part_r[7:0]   <= bus.in_data;
              2'd1: part_r[15:8]  <= bus.in_data;
              2'd2: part_r[23:16] <= bus.in_data;
              2'd3: begin
                we_r       <= 1'b1;
                addr_r     <= word_cnt_r[ADDR_W-1:0];
                wdata_r    <= {bus.in_data, part_r};
                word_cnt_r <= word_cnt_r + CNT_W'(1);
              end
              default: part_r <= part_r;
            endcase
          end
          default: csum_r <= csum_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic core_reset, load_done, load_error;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b [12];
    int          nb;
    int          exp_nwr;
    logic [31:0] exp_last;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs [7];

  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W+31:0] wr_q [$];
  logic [ADDR_W+31:0] exp_q [$];
  logic [7:0]         frame_q [$];
  bit exp_done, exp_err;
  bit prev_we = 1'b0;
  bit frame_abort = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: records every strobe and checks the strobe never repeats on consecutive cycles.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      check("we_back_to_back", 64'(prev_we), 64'd0);
      wr_q.push_back({bus.imem_addr, bus.imem_wdata});
    end
    prev_we <= (bus.imem_we === 1'b1);
  end

  // Reference model: expected writes and final status straight from the frame rules.
  task automatic model();
    int count;
    logic [7:0] cs;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    count = int'(frame_q[0]) + 256 * int'(frame_q[1]);
    if (count > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      cs = 8'h00;
      for (int i = 0; i < 2 + 4 * count; i++) cs = cs ^ frame_q[i];
      for (int w = 0; w < count; w++)
        exp_q.push_back({ADDR_W'(w), frame_q[2+4*w+3], frame_q[2+4*w+2],
                         frame_q[2+4*w+1], frame_q[2+4*w]});
      exp_done = (frame_q[2 + 4 * count] == cs);
      exp_err  = !exp_done;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited = 0;
    bit sent = 1'b0;
    while (!sent && !frame_abort) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        if (bus.in_ready === 1'b1) begin
          sent = 1'b1;
        end else if (waited > 40) begin
          n_checks++;
          n_fail++;
          $display("FAIL in_ready_timeout: actual in_ready low for %0d cycles, required high", waited);
          frame_abort = 1'b1;
          bus.in_valid = 1'b0;
        end else begin
          waited++;
        end
      end
    end
    if (sent) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    frame_abort = 1'b0;
    wr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},         64'(bus.imem_we),    64'd0);
    check({tag, "_addr"},       64'(bus.imem_addr),  64'd0);
    check({tag, "_wdata"},      64'(bus.imem_wdata), 64'd0);
    check({tag, "_core_reset"}, 64'(core_reset),     64'd1);
    check({tag, "_load_done"},  64'(load_done),      64'd0);
    check({tag, "_load_error"}, 64'(load_error),     64'd0);
    check({tag, "_in_ready"},   64'(bus.in_ready),   64'd1);
  endtask

  task automatic run_frame(input bit rst, input bit gaps);
    int n;
    if (rst) do_reset();
    model();
    foreach (frame_q[i]) send_byte(frame_q[i], gaps);
    idle(4);
    check("n_writes", 64'(wr_q.size()), 64'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("write_addr_data", 64'(wr_q[i]), 64'(exp_q[i]));
    check("load_done",  64'(load_done),    64'(exp_done));
    check("load_error", 64'(load_error),   64'(exp_err));
    check("core_reset", 64'(core_reset),   64'(!exp_done));
    check("in_ready",   64'(bus.in_ready), 64'(!exp_done));
  endtask

  task automatic build_random(input int count, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(count[7:0]);
    frame_q.push_back(count[15:8]);
    if (count > DEPTH) begin
      repeat ($urandom_range(0, 6)) frame_q.push_back(8'($urandom));
    end else begin
      repeat (4 * count) frame_q.push_back(8'($urandom));
      cs = 8'h00;
      foreach (frame_q[i]) cs = cs ^ frame_q[i];
      b = 8'($urandom_range(1, 255));
      frame_q.push_back(corrupt ? (cs ^ b) : cs);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    vecs[0] = '{'{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 7, 1, 32'h00500013, 1'b1, 1'b0};
    vecs[1] = '{'{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00}, 9, 1, 32'h00500013, 1'b0, 1'b1};
    vecs[2] = '{'{8'h41, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 0, 32'h0, 1'b0, 1'b1};
    vecs[3] = '{'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 32'h0, 1'b1, 1'b0};
    vecs[4] = '{'{8'h00, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 32'h0, 1'b0, 1'b1};
    vecs[5] = '{'{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8A, 8'h00}, 11, 2, 32'h88776655, 1'b1, 1'b0};
    vecs[6] = '{'{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 32'h0, 1'b0, 1'b1};

    // Reset values while reset is held.
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Table vectors.
    foreach (vecs[v]) begin
      frame_q.delete();
      for (int i = 0; i < vecs[v].nb; i++) frame_q.push_back(vecs[v].b[i]);
      run_frame(1'b1, 1'b0);
      check("tbl_nwr",  64'(wr_q.size()), 64'(vecs[v].exp_nwr));
      if (vecs[v].exp_nwr > 0 && wr_q.size() > 0)
        check("tbl_last_wdata", 64'(wr_q[wr_q.size()-1][31:0]), 64'(vecs[v].exp_last));
      check("tbl_done", 64'(load_done),  64'(vecs[v].exp_done));
      check("tbl_err",  64'(load_error), 64'(vecs[v].exp_err));
    end

    // Exact latency of the write strobe and of load_done on the 1-word frame.
    do_reset();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h50, 1'b0);
    idle(1);
    check("t_we_before_lane3", 64'(bus.imem_we), 64'd0);
    send_byte(8'h00, 1'b0);
    idle(1);
    check("t_we_after_lane3", 64'(bus.imem_we),    64'd1);
    check("t_addr",           64'(bus.imem_addr),  64'd0);
    check("t_wdata",          64'(bus.imem_wdata), 64'h00500013);
    idle(1);
    check("t_we_one_cycle",   64'(bus.imem_we),    64'd0);
    check("t_wdata_held",     64'(bus.imem_wdata), 64'h00500013);
    check("t_done_early",     64'(load_done),      64'd0);
    send_byte(8'h42, 1'b0);
    idle(1);
    check("t_done",       64'(load_done),    64'd1);
    check("t_core_reset", 64'(core_reset),   64'd0);
    check("t_in_ready",   64'(bus.in_ready), 64'd0);

    // Reset after 2 of 4 bytes of word 1 in a 3-word frame.
    do_reset();
    frame_q = '{8'h03, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    check("midreset_writes", 64'(wr_q.size()), 64'd1);

    // Reset on the same edge as lane 3 cancels the pending write.
    reset = 1'b0;
    wr_q.delete();
    frame_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hDD;
    reset = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    idle(2);
    check("cancel_writes",     64'(wr_q.size()), 64'd0);
    check("cancel_core_reset", 64'(core_reset),  64'd1);

    // Fresh 1-word frame after the mid-frame reset, no extra reset.
    frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h42};
    run_frame(1'b0, 1'b0);

    // Full-depth frame with random gaps.
    build_random(DEPTH, 1'b0);
    run_frame(1'b1, 1'b1);

    // Random frames: legal lengths, some corrupted, some oversized.
    for (int k = 0; k < 8; k++) begin
      if (k >= 6) build_random($urandom_range(DEPTH + 1, 300), 1'b0);
      else        build_random($urandom_range(0, DEPTH), ($urandom_range(0, 2) == 0));
      run_frame(1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
